// File: rtl/fsm_seq_transmitter_if.sv
// fsm_seq_transmitter_if: start/pattern request and serial x stream between a transmitter and its user
interface fsm_seq_transmitter_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             done;
    modport master (output start, pattern, repeat_cnt, input x_out, x_valid, busy, done);
    modport slave  (input start, pattern, repeat_cnt, output x_out, x_valid, busy, done);
endinterface

// File: rtl/fsm_seq_transmitter.sv
// fsm_seq_transmitter: shifts a latched pattern out MSB-first, repeat_cnt times, with GAP idle cycles between repeats
module fsm_seq_transmitter #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input logic                 clk,
    input logic                 reset,
    fsm_seq_transmitter_if.slave bus
);
    localparam int BW = $clog2(PAT_W);
    localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;
    state_t           state;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] rem;
    logic [BW-1:0]    bidx;
    logic [GW-1:0]    gcnt;
    logic             x_out, x_valid, busy, done;
    assign bus.x_out   = x_out;
    assign bus.x_valid = x_valid;
    assign bus.busy    = busy;
    assign bus.done    = done;
    // bidx is the index of the bit on x_out in the cycle after the edge that set it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            pat     <= '0;
            rem     <= '0;
            bidx    <= '0;
            gcnt    <= '0;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    pat <= bus.pattern;
                    rem <= bus.repeat_cnt;
                    if (bus.repeat_cnt != '0) begin
                        state   <= S_SHIFT;
                        bidx    <= BW'(PAT_W - 1);
                        x_out   <= bus.pattern[PAT_W-1];
                        x_valid <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_SHIFT: if (bidx != '0) begin
                    bidx  <= bidx - 1'b1;
                    x_out <= pat[bidx - 1'b1];
                end else begin
                    rem <= rem - 1'b1;
                    if (rem == CNT_W'(1)) begin
                        state   <= S_DONE;
                        x_out   <= 1'b0;
                        x_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (GAP > 0) begin
                        state   <= S_GAP;
                        gcnt    <= GW'(GAP);
                        x_out   <= 1'b0;
                        x_valid <= 1'b0;
                    end else begin
                        bidx  <= BW'(PAT_W - 1);
                        x_out <= pat[PAT_W-1];
                    end
                end
                S_GAP: if (gcnt == GW'(1)) begin
                    state   <= S_SHIFT;
                    bidx    <= BW'(PAT_W - 1);
                    x_out   <= pat[PAT_W-1];
                    x_valid <= 1'b1;
                end else begin
                    gcnt <= gcnt - 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fsm_seq_transmitter.sv
// tb_fsm_seq_transmitter: table of runs checked cycle by cycle against a queue of expected outputs
module tb_fsm_seq_transmitter;
    localparam int PAT_W = 4, CNT_W = 4, GAP = 2;
    typedef struct {logic v; logic x; logic b; logic d;} exp_t;
    typedef struct {logic [3:0] pat; logic [3:0] rc; int blen; bit mid; bit sid;} vec_t;
    logic clk = 1'b0;
    logic reset;
    int checks = 0, failures = 0;
    exp_t sb[$];
    vec_t tbl[6];
    fsm_seq_transmitter_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();
    fsm_seq_transmitter #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask
    task automatic idle_chk(input string tag);
        chk({tag, "_x_out"}, {31'd0, bus.x_out}, 0);
        chk({tag, "_x_valid"}, {31'd0, bus.x_valid}, 0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
        chk({tag, "_done"}, {31'd0, bus.done}, 0);
    endtask
    task automatic run(input vec_t v);
        int nb = 0, idx = 0;
        exp_t e;
        for (int r = 0; r < int'(v.rc); r++) begin
            if (r > 0) repeat (GAP) sb.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
            for (int i = PAT_W - 1; i >= 0; i--) sb.push_back('{1'b1, v.pat[i], 1'b1, 1'b0});
        end
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        bus.start = 1'b1;
        bus.pattern = v.pat;
        bus.repeat_cnt = v.rc;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            chk("x_valid", {31'd0, bus.x_valid}, {31'd0, e.v});
            chk("x_out", {31'd0, bus.x_out}, {31'd0, e.x});
            chk("busy", {31'd0, bus.busy}, {31'd0, e.b});
            chk("done", {31'd0, bus.done}, {31'd0, e.d});
            nb += int'(bus.busy);
            bus.start = (v.mid && idx == 2) || (v.sid && e.d);
            bus.pattern = v.mid ? 4'b0000 : 4'b1111;
            bus.repeat_cnt = 4'd1;
            idx++;
        end
        chk("busy_len", nb, v.blen);
        @(negedge clk);
        bus.start = 1'b0;
        idle_chk("post_run");
    endtask
    initial begin
        tbl[0] = '{4'b1011, 4'd1, 4, 1'b0, 1'b0};
        tbl[1] = '{4'b1011, 4'd2, 10, 1'b0, 1'b0};
        tbl[2] = '{4'b1011, 4'd0, 0, 1'b0, 1'b0};
        tbl[3] = '{4'b1011, 4'd2, 10, 1'b1, 1'b1};
        tbl[4] = '{4'b1001, 4'd3, 16, 1'b0, 1'b1};
        tbl[5] = '{4'b1100, 4'd15, 88, 1'b0, 1'b0};
        bus.start = 1'b1;
        bus.pattern = 4'b1111;
        bus.repeat_cnt = 4'd1;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 idle_chk("rst_async");
        repeat (3) begin
            @(negedge clk);
            idle_chk("rst_held");
        end
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            idle_chk("quiet");
        end
        for (int i = 0; i < 6; i++) run(tbl[i]);
        @(negedge clk);
        bus.start = 1'b1;
        bus.pattern = 4'b1011;
        bus.repeat_cnt = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mid_rst_b0", {31'd0, bus.x_out}, 1);
        chk("mid_rst_v0", {31'd0, bus.x_valid}, 1);
        @(negedge clk);
        chk("mid_rst_b1", {31'd0, bus.x_out}, 0);
        chk("mid_rst_v1", {31'd0, bus.x_valid}, 1);
        chk("mid_rst_busy", {31'd0, bus.busy}, 1);
        #2 reset = 1'b0;
        #1 idle_chk("mid_rst_async");
        @(negedge clk);
        idle_chk("mid_rst_held");
        reset = 1'b1;
        @(negedge clk);
        idle_chk("mid_rst_release");
        run('{4'b0110, 4'd1, 4, 1'b0, 1'b0});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
